// File: rtl/pc_stack_pkg.sv
// Shared definitions for the pc_stack fetch-path program counter: default word width,
// op-select encoding and the load > call > ret > incr > hold priority encoder.
package pc_stack_pkg;

  localparam int HACK_WORD_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INCR = 3'd1,
    OP_LOAD = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } op_e;

  typedef struct packed {
    logic load;
    logic call;
    logic ret;
    logic incr;
  } ctl_t;

  // A return on an empty stack degrades to a plain increment.
  function automatic op_e op_sel(input ctl_t c, input logic empty);
    op_e op;
    op = OP_HOLD;
    if (c.load)      op = OP_LOAD;
    else if (c.call) op = OP_CALL;
    else if (c.ret)  op = empty ? OP_INCR : OP_RET;
    else if (c.incr) op = OP_INCR;
    return op;
  endfunction

endpackage

// File: rtl/pc_stack_ret_stack.sv
// Return-address LIFO: push writes stack[count], pop exposes stack[count-1].
// Push when full and pop when empty are dropped here; the caller owns priority.
module ret_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wr_idx  = AW'(cnt);
  // Park the read index at 0 when empty so a non-power-of-2 DEPTH never reads past the array.
  assign rd_idx  = empty ? '0 : AW'(cnt - CW'(1));
  assign top     = mem[rd_idx];
  assign count   = cnt;

  // Storage is intentionally not reset; only the count defines valid entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset)       cnt <= '0;
    else if (do_push) cnt <= cnt + CW'(1);
    else if (do_pop)  cnt <= cnt - CW'(1);
  end

endmodule

// File: rtl/pc_stack.sv
// Hack-style program counter with hardware call/return through ret_stack.
// Optional sticky overflow/underflow flag enabled by defining PC_STACK_ERR_EN.
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int WIDTH = HACK_WORD_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in,
  input  logic                       incr,
  input  logic                       load,
  input  logic                       call,
  input  logic                       ret,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       err
);

  ctl_t             ctl;
  op_e              op;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] top;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign ctl    = '{load: load, call: call, ret: ret, incr: incr};
  assign op     = op_sel(ctl, empty);
  assign pc_inc = pc_q + WIDTH'(1);
  assign push   = (op == OP_CALL) && !full;
  assign pop    = (op == OP_RET);

  ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (top),
    .count (depth),
    .full  (full),
    .empty (empty)
  );

  // A call on a full stack still takes the jump; only the push is lost.
  always_ff @(posedge clk) begin
    if (!reset) pc_q <= '0;
    else begin
      case (op)
        OP_LOAD, OP_CALL: pc_q <= in;
        OP_RET:           pc_q <= top;
        OP_INCR:          pc_q <= pc_inc;
        default:          pc_q <= pc_q;
      endcase
    end
  end

  assign out = pc_q;

`ifdef PC_STACK_ERR_EN
  logic err_q;
  logic ovf;
  logic unf;

  assign ovf = call && !load && full;
  assign unf = ret && !load && !call && empty;

  always_ff @(posedge clk) begin
    if (!reset)         err_q <= 1'b0;
    else if (ovf | unf) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack (WIDTH=16, DEPTH=8); expected err follows PC_STACK_ERR_EN.
module tb_pc_stack;

`ifdef PC_STACK_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        incr, load, call, ret;
  logic [15:0] out;
  logic [3:0]  depth;
  logic        err;

  int total = 0;
  int bad   = 0;

  pc_stack #(.WIDTH(16), .DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .incr  (incr),
    .load  (load),
    .call  (call),
    .ret   (ret),
    .out   (out),
    .depth (depth),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    incr = 0; load = 0; call = 0; ret = 0;
  endtask

  task automatic test_reset();
    reset = 0; idle(); in = 16'd12345; load = 1;
    tick();
    total++; if (out !== 16'd0) begin bad++; $display("FAIL reset_out got=%0d want=0", out); end
    total++; if (depth !== 4'd0) begin bad++; $display("FAIL reset_depth got=%0d want=0", depth); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", err); end
    reset = 1;
    tick();
    total++; if (out !== 16'd12345) begin bad++; $display("FAIL load_after_reset got=%0d want=12345", out); end
    idle();
  endtask

  task automatic test_incr();
    load = 1; in = 16'd0; tick(); idle();
    incr = 1;
    tick();
    total++; if (out !== 16'd1) begin bad++; $display("FAIL incr1 got=%0d want=1", out); end
    tick();
    total++; if (out !== 16'd2) begin bad++; $display("FAIL incr2 got=%0d want=2", out); end
    idle(); load = 1; in = 16'hFFFF; tick(); idle();
    total++; if (out !== 16'hFFFF) begin bad++; $display("FAIL load_ffff got=%h want=ffff", out); end
    incr = 1; tick(); idle();
    total++; if (out !== 16'd0) begin bad++; $display("FAIL incr_wrap got=%h want=0000", out); end
  endtask

  task automatic test_call_ret();
    load = 1; in = 16'd5; tick(); idle();
    call = 1; in = 16'd100; tick(); idle();
    total++; if (out !== 16'd100) begin bad++; $display("FAIL call_out got=%0d want=100", out); end
    total++; if (depth !== 4'd1) begin bad++; $display("FAIL call_depth got=%0d want=1", depth); end
    incr = 1; tick(); tick(); tick(); idle();
    total++; if (out !== 16'd103) begin bad++; $display("FAIL incr3 got=%0d want=103", out); end
    ret = 1; tick(); idle();
    total++; if (out !== 16'd6) begin bad++; $display("FAIL ret_out got=%0d want=6", out); end
    total++; if (depth !== 4'd0) begin bad++; $display("FAIL ret_depth got=%0d want=0", depth); end
  endtask

  // Calls from 10,20..80 push 11,21..81; the 9th call overflows.
  task automatic test_nested();
    load = 1; in = 16'd10; tick(); idle();
    for (int i = 1; i <= 8; i++) begin
      call = 1; in = 16'((i + 1) * 10); tick(); idle();
      total++; if (depth !== 4'(i)) begin bad++; $display("FAIL nest_depth%0d got=%0d want=%0d", i, depth, i); end
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL nest_err_pre got=%0b want=0", err); end
    call = 1; in = 16'd999; tick(); idle();
    total++; if (out !== 16'd999) begin bad++; $display("FAIL ovf_out got=%0d want=999", out); end
    total++; if (depth !== 4'd8) begin bad++; $display("FAIL ovf_depth got=%0d want=8", depth); end
    total++; if (err !== ERR_EN) begin bad++; $display("FAIL ovf_err got=%0b want=%0b", err, ERR_EN); end
    for (int i = 8; i >= 1; i--) begin
      ret = 1; tick(); idle();
      total++; if (out !== 16'(i * 10 + 1)) begin bad++; $display("FAIL nest_ret%0d got=%0d want=%0d", i, out, i * 10 + 1); end
      total++; if (depth !== 4'(i - 1)) begin bad++; $display("FAIL nest_rdepth%0d got=%0d want=%0d", i, depth, i - 1); end
    end
  endtask

  task automatic test_underflow();
    reset = 0; tick(); reset = 1;
    load = 1; in = 16'd7; tick(); idle();
    ret = 1; tick(); idle();
    total++; if (out !== 16'd8) begin bad++; $display("FAIL unf_out got=%0d want=8", out); end
    total++; if (depth !== 4'd0) begin bad++; $display("FAIL unf_depth got=%0d want=0", depth); end
    total++; if (err !== ERR_EN) begin bad++; $display("FAIL unf_err got=%0b want=%0b", err, ERR_EN); end
    tick();
    total++; if (err !== ERR_EN) begin bad++; $display("FAIL unf_sticky got=%0b want=%0b", err, ERR_EN); end
    total++; if (out !== 16'd8) begin bad++; $display("FAIL hold got=%0d want=8", out); end
  endtask

  task automatic test_priority();
    reset = 0; tick(); reset = 1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%0b want=0", err); end
    call = 1; in = 16'd1; tick(); idle();
    load = 1; call = 1; ret = 1; incr = 1; in = 16'h8285; tick(); idle();
    total++; if (out !== 16'h8285) begin bad++; $display("FAIL prio_load got=%h want=8285", out); end
    total++; if (depth !== 4'd1) begin bad++; $display("FAIL prio_load_depth got=%0d want=1", depth); end
    call = 1; ret = 1; in = 16'd40; tick(); idle();
    total++; if (out !== 16'd40) begin bad++; $display("FAIL prio_callret got=%0d want=40", out); end
    total++; if (depth !== 4'd2) begin bad++; $display("FAIL prio_callret_depth got=%0d want=2", depth); end
    ret = 1; tick(); idle();
    total++; if (out !== 16'h8286) begin bad++; $display("FAIL prio_ret got=%h want=8286", out); end
    call = 1; in = 16'd50; tick(); call = 1; in = 16'd60; tick(); idle();
    total++; if (depth !== 4'd3) begin bad++; $display("FAIL pre_reset_depth got=%0d want=3", depth); end
    reset = 0; call = 1; in = 16'd77; tick(); reset = 1; idle();
    total++; if (out !== 16'd0) begin bad++; $display("FAIL midcall_reset_out got=%0d want=0", out); end
    total++; if (depth !== 4'd0) begin bad++; $display("FAIL midcall_reset_depth got=%0d want=0", depth); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL midcall_reset_err got=%0b want=0", err); end
  endtask

  task automatic test_ret_wrap();
    load = 1; in = 16'hFFFF; tick(); idle();
    call = 1; in = 16'd300; tick(); idle();
    ret = 1; tick(); idle();
    total++; if (out !== 16'd0) begin bad++; $display("FAIL ret_wrap got=%h want=0000", out); end
  endtask

  initial begin
    reset = 0; in = '0; idle();
    test_reset();
    test_incr();
    test_call_ret();
    test_nested();
    test_underflow();
    test_priority();
    test_ret_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
